// File: rtl/fir_pkg.sv
// Shared types and helpers for the multi-channel streaming FIR.
// Sizing helpers and the output clamp live here so every unit agrees.
package fir_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      ROUND,
      OUT
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic int acc_w(input int dw, input int cw, input int taps);
      return dw + cw + clog2(taps);
   endfunction

   function automatic logic signed [63:0] sat_val(
      input logic signed [63:0] v,
      input int                 w
   );
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic logic sat_hit(
      input logic signed [63:0] v,
      input int                 w
   );
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      return (v > hi) || (v < lo);
   endfunction

endpackage

// File: rtl/fir_stream_mc_mac.sv
// Shared multiply-accumulate with round-half-up shift and clamp.
// The rounded result is combinational; the caller registers it.
module fir_mac
   import fir_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int ACC_W  = 36,
   parameter int SHIFT  = 15
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic                     clr,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] x,
   input  logic signed [COEF_W-1:0] c,
   output logic signed [DATA_W-1:0] res,
   output logic                     sat
);

   localparam int PW = DATA_W + COEF_W;
   localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [ACC_W:0] RND =
      (SHIFT > 0) ? (ACC_W + 1)'(1) <<< RS : '0;

   logic signed [ACC_W-1:0] acc;
   logic signed [PW-1:0]    prod;
   logic signed [ACC_W:0]   biased;
   logic signed [ACC_W:0]   shifted;
   logic signed [63:0]      wide;

   assign prod = x * c;

   always_ff @(posedge aclk) begin
      if (areset || clr)
         acc <= '0;
      else if (en)
         acc <= acc + ACC_W'(prod);
   end

   // One guard bit so the rounding bias cannot wrap the accumulator.
   assign biased  = (ACC_W + 1)'(acc) + RND;
   assign shifted = biased >>> SHIFT;
   assign wide    = 64'(shifted);
   assign res     = DATA_W'(sat_val(wide, DATA_W));
   assign sat     = sat_hit(wide, DATA_W);

endmodule

// File: rtl/fir_stream_mc.sv
// Time-multiplexed multi-channel FIR: FSM, delay lines, coefficients.
// One shared MAC walks all taps of the current channel per sample.
module fir_stream_mc
   import fir_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int COEF_W   = 16,
   parameter int TAPS     = 16,
   parameter int CHANNELS = 2,
   parameter int SHIFT    = 15,
   localparam int AW      = clog2(TAPS),
   localparam int CW      = (clog2(CHANNELS) > 0) ? clog2(CHANNELS) : 1,
   localparam int ACC_W   = acc_w(DATA_W, COEF_W, TAPS)
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic                     s_axis_data_tvalid,
   output logic                     s_axis_data_tready,
   input  logic signed [DATA_W-1:0] s_axis_data_tdata,
   output logic                     m_axis_data_tvalid,
   input  logic                     m_axis_data_tready,
   output logic signed [DATA_W-1:0] m_axis_data_tdata,
   output logic [CW-1:0]            m_axis_data_tuser,
   input  logic                     cfg_coef_we,
   input  logic [AW-1:0]            cfg_coef_addr,
   input  logic signed [COEF_W-1:0] cfg_coef_data,
   output logic                     cfg_coef_ready,
   output logic                     sat_sticky
);

   state_t                   state;
   logic                     run;
   logic [CW-1:0]            ch;
   logic [AW-1:0]            tap;
   logic [AW-1:0]            wptr  [CHANNELS];
   logic signed [DATA_W-1:0] dline [CHANNELS][TAPS];
   logic signed [COEF_W-1:0] coef  [TAPS];

   logic                     accept;
   logic [AW-1:0]            rd_idx;
   logic signed [DATA_W-1:0] mac_res;
   logic                     mac_sat;

   // run keeps the block closed while reset is held.
   assign s_axis_data_tready = run && (state == IDLE);
   assign cfg_coef_ready     = run && (state == IDLE);
   assign accept = s_axis_data_tvalid && s_axis_data_tready;
   assign rd_idx = wptr[ch] - tap;

   fir_mac #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W),
      .SHIFT  (SHIFT)
   ) u_mac (
      .aclk   (aclk),
      .areset (areset),
      .clr    (accept),
      .en     (state == MAC),
      .x      (dline[ch][rd_idx]),
      .c      (coef[tap]),
      .res    (mac_res),
      .sat    (mac_sat)
   );

   always_ff @(posedge aclk) begin
      if (areset) begin
         state              <= IDLE;
         run                <= 1'b0;
         ch                 <= '0;
         tap                <= '0;
         m_axis_data_tvalid <= 1'b0;
         m_axis_data_tdata  <= '0;
         m_axis_data_tuser  <= '0;
         sat_sticky         <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) begin
            wptr[c] <= '0;
            for (int t = 0; t < TAPS; t++)
               dline[c][t] <= '0;
         end
         for (int t = 0; t < TAPS; t++)
            coef[t] <= '0;
      end else begin
         run <= 1'b1;
         unique case (state)
            IDLE: begin
               if (cfg_coef_we && cfg_coef_ready)
                  coef[cfg_coef_addr] <= cfg_coef_data;
               if (accept) begin
                  dline[ch][wptr[ch]] <= s_axis_data_tdata;
                  tap                 <= '0;
                  state               <= MAC;
               end
            end
            MAC: begin
               tap <= tap + 1'b1;
               if (tap == AW'(TAPS - 1))
                  state <= ROUND;
            end
            ROUND: begin
               m_axis_data_tdata  <= mac_res;
               m_axis_data_tuser  <= ch;
               m_axis_data_tvalid <= 1'b1;
               if (mac_sat)
                  sat_sticky <= 1'b1;
               wptr[ch] <= wptr[ch] + 1'b1;
               ch <= (ch == CW'(CHANNELS - 1)) ? '0 : ch + 1'b1;
               state <= OUT;
            end
            OUT: begin
               if (m_axis_data_tready) begin
                  m_axis_data_tvalid <= 1'b0;
                  state              <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/fir_stream_mc.md
# fir_stream_mc

Parametrised, multi-channel, time-multiplexed FIR filter with AXI-stream-style data ports and run-time loadable coefficients. It is the next-generation replacement for the fixed single-channel audio FIR core used in the filtering chain. Input samples from CHANNELS interleaved streams go through one shared multiply-accumulate unit, with rounding, saturation and output backpressure.

## Interface
- DATA_W, 16, signed sample width (in and out)
- COEF_W, 16, signed coefficient width
- TAPS, 16, filter length (≥2, power of two)
- CHANNELS, 2, interleaved channel count (≥1)
- SHIFT, 15, arithmetic right shift applied to the accumulator before saturation
- aclk  in  1  clock; one clock, all logic on rising edge
- areset  in  1  reset, synchronous, active-high
- s_axis_data_tvalid  in  1  input sample valid
- s_axis_data_tready  out  1  block can accept a sample
- s_axis_data_tdata  in  DATA_W  signed input sample
- m_axis_data_tvalid  out  1  output sample valid
- m_axis_data_tready  in  1  downstream accepts output
- m_axis_data_tdata  out  DATA_W  signed filtered sample
- m_axis_data_tuser  out  max(1,clog2(CHANNELS))  channel index of the output sample
- cfg_coef_we  in  1  coefficient write strobe
- cfg_coef_addr  in  clog2(TAPS)  tap index
- cfg_coef_data  in  COEF_W  signed coefficient
- cfg_coef_ready  out  1  high when a coefficient write takes effect
- sat_sticky  out  1  set when any output saturated; cleared only by reset

## Operation
- Input channels arrive round-robin. The first sample accepted after reset is channel 0. The channel counter wraps at CHANNELS-1.
- Delay line: CHANNELS×TAPS register array, with one circular write pointer per channel. On accept, the sample is written at wptr[ch].
- Tap i uses x[(wptr[ch]−i) mod TAPS] × coef[i].
- FSM states:
  - IDLE: s_tready=1 and cfg_coef_ready=1. On accept, go to MAC with tap=0 and acc=0.
  - MAC: one product per cycle, acc += x·coef. After tap TAPS−1, go to ROUND.
  - ROUND: compute out = sat_DATA_W((acc + (SHIFT>0 ? 1<<(SHIFT−1) : 0)) >>> SHIFT), which is round-half-up. Register tdata and tuser, advance wptr[ch] mod TAPS, advance the channel counter, then go to OUT.
  - OUT: m_tvalid=1. When m_tready is high, complete the handshake and go to IDLE.
- Accumulator width: ACC_W = DATA_W+COEF_W+clog2(TAPS). Full-precision signed products; no intermediate overflow is possible.
- Saturation clamps to [−2^(DATA_W−1), 2^(DATA_W−1)−1] and sets sat_sticky.
- cfg_coef_we is applied only in IDLE. A write outside IDLE is ignored.
- Reset values:
  - s_tready=0 during reset, then 1 on the first cycle after reset.
  - m_tvalid=0, m_tdata=0, m_tuser=0, sat_sticky=0.
  - All coefficients, delay-line entries, pointers, accumulator and channel counter are 0. The FSM goes to IDLE.
- Reset mid-operation discards any in-flight result. No output is produced for it.

## Timing
- The accept edge is edge 0. MAC products are taken on edges 1..TAPS. ROUND is on edge TAPS+1, and m_tvalid is high from edge TAPS+1.
- With m_tready held at 1, the handshake happens on edge TAPS+2 and the next accept on edge TAPS+3. Sustained throughput is one sample per TAPS+3 cycles.
- While m_tvalid=1 and m_tready=0, tdata and tuser hold stable and s_tready stays 0.
- s_tready and cfg_coef_ready are combinational from the state register only, with no combinational path from any input.
- A cfg write and an input accept may occur on the same edge in IDLE. The new coefficient is then used by that sample.

## Structure
- Package fir_pkg:
  - state enum (IDLE, MAC, ROUND, OUT)
  - ACC_W derivation function
  - clog2 helper
  - saturation function
- Sub-module fir_mac: signed multiply, accumulate, clear, round-shift-saturate, and sat flag. The top level holds the FSM, delay line, pointers and coefficient registers.

## Test plan
- Impulse: h[i]=(i+1)·256 and CHANNELS=1. Input 16384, then zeros. Outputs must be 128, 256, …, TAPS·128, then 0, and sat_sticky=0.
- Channel isolation: CHANNELS=2 with the same coefficients. Ch0 gets the impulse, ch1 gets a constant 0. tuser must alternate 0,1. Ch1 outputs must all be 0, and ch0 outputs must match the impulse case.
- Saturation: all coefficients 32767 and input 32767 for TAPS samples. The last output must be 32767 and sat_sticky=1. With input −32768 the output must be −32768.
- Rounding: only h[0]=16384. Input 3 must give 2. Input −3 must give −1. Input 1 must give 1 (0.5 rounds up).
- Backpressure: hold m_tready=0 for 10 cycles with a result pending. tvalid, tdata and tuser must stay stable and s_tready must stay 0. After release, no sample is lost or duplicated.
- Reset mid-MAC: assert areset at tap 5. On the next cycle m_tvalid must be 0, then s_tready=1. Coefficients read as 0, so a later impulse after reload gives a clean response with no residue.
